// File: rtl/ahb_mux_nm1s.sv
// N-master to 1-slave AHB-Lite interconnect.
// Each master owns one pending register. The current owner's transfer goes
// straight to the slave. Any other master's transfer is captured and sent
// later. Ownership is arbitrated (fixed priority or round-robin) and can only
// change while HREADY is high. SEQ beats keep the current owner so that a
// burst is not split.
module ahb_mux_nm1s #(
  parameter int unsigned NM = 2,
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 32,
  parameter int unsigned RR = 1
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NM*AW-1:0]   M_HADDR,
  input  logic [NM*2-1:0]    M_HTRANS,
  input  logic [NM-1:0]      M_HWRITE,
  input  logic [NM*3-1:0]    M_HSIZE,
  input  logic [NM*DW-1:0]   M_HWDATA,
  output logic [NM-1:0]      M_HREADY,
  output logic [NM-1:0]      M_HRESP,
  output logic [DW-1:0]      M_HRDATA,
  output logic [AW-1:0]      HADDR,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [2:0]         HSIZE,
  output logic [DW-1:0]      HWDATA,
  input  logic               HREADY,
  input  logic               HRESP,
  input  logic [DW-1:0]      HRDATA,
  output logic [NM-1:0]      GNT
);

  localparam int unsigned OW = (NM > 1) ? $clog2(NM) : 1;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_SEQ  = 2'b11;

  typedef enum logic [1:0] {
    MI = 2'b00,
    MW = 2'b01,
    MD = 2'b10
  } mst_state_t;

  // Live per-master request fields, unpacked from the flat buses
  logic [AW-1:0] l_addr  [NM];
  logic [1:0]    l_trans [NM];
  logic          l_write [NM];
  logic [2:0]    l_size  [NM];
  logic [DW-1:0] l_wdata [NM];

  // Per-master state and pending (captured) address-phase registers
  mst_state_t    st_q [NM];
  mst_state_t    st_d [NM];
  logic [AW-1:0] pa_q [NM];
  logic [1:0]    pt_q [NM];
  logic          pw_q [NM];
  logic [2:0]    ps_q [NM];

  logic [NM-1:0] req;
  logic [NM-1:0] acc;
  logic [NM-1:0] cap;
  logic [NM-1:0] wset;

  logic [OW-1:0] own_q;
  logic [OW-1:0] own_d;
  logic          dv_q;
  logic [OW-1:0] down_q;

  // Address-phase source selected for the slave
  logic [AW-1:0] s_addr;
  logic [1:0]    s_trans;
  logic          s_write;
  logic [2:0]    s_size;
  logic          s_req;

  // Unpack flat master buses; BUSY/IDLE are both non-requests
  always_comb begin
    for (int unsigned i = 0; i < NM; i++) begin
      l_addr[i]  = M_HADDR[i*AW +: AW];
      l_trans[i] = M_HTRANS[i*2 +: 2];
      l_write[i] = M_HWRITE[i];
      l_size[i]  = M_HSIZE[i*3 +: 3];
      l_wdata[i] = M_HWDATA[i*DW +: DW];
      req[i]     = M_HTRANS[i*2 + 1];
    end
  end

  // Per-master ready as seen by each master, and address acceptance
  always_comb begin
    M_HREADY = '1;
    for (int unsigned i = 0; i < NM; i++) begin
      case (st_q[i])
        MI:      M_HREADY[i] = 1'b1;
        MW:      M_HREADY[i] = 1'b0;
        MD:      M_HREADY[i] = HREADY;
        default: M_HREADY[i] = 1'b1;
      endcase
    end
    acc = req & M_HREADY;
  end

  // Per-master next state: direct forward, capture, pending issue, retire
  always_comb begin
    for (int unsigned i = 0; i < NM; i++) begin
      st_d[i] = st_q[i];
      cap[i]  = 1'b0;
      if (acc[i]) begin
        // An accepting master is never in MW, so owner + HREADY means direct forward
        if ((OW'(i) == own_q) && HREADY) begin
          st_d[i] = MD;
        end else begin
          st_d[i] = MW;
          cap[i]  = 1'b1;
        end
      end else if ((st_q[i] == MW) && (OW'(i) == own_q) && HREADY) begin
        st_d[i] = MD;
      end else if ((st_q[i] == MD) && HREADY) begin
        st_d[i] = MI;
      end
    end
  end

  // Waiting set seen by the arbiter includes masters captured this cycle,
  // so a freshly captured transfer can win ownership for the next cycle
  always_comb begin
    for (int unsigned i = 0; i < NM; i++) begin
      wset[i] = (st_d[i] == MW);
    end
  end

  // Slave address-phase source: owner's pending register or its live bus
  always_comb begin
    if (st_q[own_q] == MW) begin
      s_addr  = pa_q[own_q];
      s_trans = pt_q[own_q];
      s_write = pw_q[own_q];
      s_size  = ps_q[own_q];
    end else begin
      s_addr  = l_addr[own_q];
      s_trans = l_trans[own_q];
      s_write = l_write[own_q];
      s_size  = l_size[own_q];
    end
    s_req  = s_trans[1];
    HTRANS = s_req ? s_trans : T_IDLE;
    HADDR  = s_req ? s_addr  : '0;
    HWRITE = s_req ? s_write : 1'b0;
    HSIZE  = s_req ? s_size  : '0;
  end

  // Owner arbitration: burst lock on SEQ, else next waiting master, else park
  always_comb begin
    int unsigned j;
    logic        found;
    own_d = own_q;
    found = 1'b0;
    j     = 0;
    if (HREADY && (HTRANS != T_SEQ)) begin
      for (int unsigned k = 0; k < NM; k++) begin
        if (RR != 0) begin
          j = 32'(own_q) + k;
          if (j >= NM) j = j - NM;
        end else begin
          j = k;
        end
        if (!found && (OW'(j) != own_q) && wset[j]) begin
          own_d = OW'(j);
          found = 1'b1;
        end
      end
    end
  end

  // One-hot grant of the address-phase owner
  always_comb begin
    GNT        = '0;
    GNT[own_q] = 1'b1;
  end

  // Per-master state and pending capture registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < NM; i++) begin
        st_q[i] <= MI;
        pa_q[i] <= '0;
        pt_q[i] <= T_IDLE;
        pw_q[i] <= 1'b0;
        ps_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NM; i++) begin
        st_q[i] <= st_d[i];
        if (cap[i]) begin
          pa_q[i] <= l_addr[i];
          pt_q[i] <= l_trans[i];
          pw_q[i] <= l_write[i];
          ps_q[i] <= l_size[i];
        end
      end
    end
  end

  // Owner and data-phase registers advance only on slave HREADY
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      own_q  <= '0;
      dv_q   <= 1'b0;
      down_q <= '0;
    end else if (HREADY) begin
      own_q  <= own_d;
      dv_q   <= s_req;
      down_q <= own_q;
    end
  end

  // Data-phase steering: write data from the data-phase owner, response to it only
  always_comb begin
    HWDATA   = dv_q ? l_wdata[down_q] : '0;
    M_HRDATA = HRDATA;
    for (int unsigned i = 0; i < NM; i++) begin
      M_HRESP[i] = HRESP & dv_q & (down_q == OW'(i));
    end
  end

endmodule

// File: tb/tb_ahb_mux_nm1s.sv
// Directed bench for ahb_mux_nm1s: a 2-master instance for the protocol
// scenarios plus two 3-master instances (round-robin and fixed priority)
// for the arbitration fairness scenario.
module tb_ahb_mux_nm1s;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic         hclk;
  logic         rst_n;

  // 2-master instance
  logic [63:0]  m_haddr;
  logic [3:0]   m_htrans;
  logic [1:0]   m_hwrite;
  logic [5:0]   m_hsize;
  logic [127:0] m_hwdata;
  logic [1:0]   m_hready;
  logic [1:0]   m_hresp;
  logic [63:0]  m_hrdata;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [63:0]  hwdata;
  logic         hready;
  logic         hresp;
  logic [63:0]  hrdata;
  logic [1:0]   gnt;

  // 3-master instances share master-side stimulus
  logic [95:0]  m3_haddr;
  logic [5:0]   m3_htrans;
  logic [2:0]   m3_hwrite;
  logic [8:0]   m3_hsize;
  logic [95:0]  m3_hwdata;
  logic [31:0]  hrdata3;

  logic [2:0]   rr_m_hready, rr_m_hresp, rr_gnt, fp_m_hready, fp_m_hresp, fp_gnt;
  logic [31:0]  rr_m_hrdata, rr_haddr, rr_hwdata, fp_m_hrdata, fp_haddr, fp_hwdata;
  logic [1:0]   rr_htrans, fp_htrans;
  logic         rr_hwrite, fp_hwrite;
  logic [2:0]   rr_hsize, fp_hsize;

  int n_chk = 0;
  int n_err = 0;

  ahb_mux_nm1s #(.NM(2), .DW(64), .AW(32), .RR(1)) u_dut (
    .HCLK(hclk), .HRESETn(rst_n),
    .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HWRITE(m_hwrite),
    .M_HSIZE(m_hsize), .M_HWDATA(m_hwdata),
    .M_HREADY(m_hready), .M_HRESP(m_hresp), .M_HRDATA(m_hrdata),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HWDATA(hwdata), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata),
    .GNT(gnt)
  );

  ahb_mux_nm1s #(.NM(3), .DW(32), .AW(32), .RR(1)) u_rr (
    .HCLK(hclk), .HRESETn(rst_n),
    .M_HADDR(m3_haddr), .M_HTRANS(m3_htrans), .M_HWRITE(m3_hwrite),
    .M_HSIZE(m3_hsize), .M_HWDATA(m3_hwdata),
    .M_HREADY(rr_m_hready), .M_HRESP(rr_m_hresp), .M_HRDATA(rr_m_hrdata),
    .HADDR(rr_haddr), .HTRANS(rr_htrans), .HWRITE(rr_hwrite), .HSIZE(rr_hsize),
    .HWDATA(rr_hwdata), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata3),
    .GNT(rr_gnt)
  );

  ahb_mux_nm1s #(.NM(3), .DW(32), .AW(32), .RR(0)) u_fp (
    .HCLK(hclk), .HRESETn(rst_n),
    .M_HADDR(m3_haddr), .M_HTRANS(m3_htrans), .M_HWRITE(m3_hwrite),
    .M_HSIZE(m3_hsize), .M_HWDATA(m3_hwdata),
    .M_HREADY(fp_m_hready), .M_HRESP(fp_m_hresp), .M_HRDATA(fp_m_hrdata),
    .HADDR(fp_haddr), .HTRANS(fp_htrans), .HWRITE(fp_hwrite), .HSIZE(fp_hsize),
    .HWDATA(fp_hwdata), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata3),
    .GNT(fp_gnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int m, input logic [1:0] t, input logic [31:0] a, input logic w);
    m_htrans[m*2 +: 2] = t;
    m_haddr[m*32 +: 32] = a;
    m_hwrite[m]         = w;
    m_hsize[m*3 +: 3]   = 3'b010;
  endtask

  task automatic nxt();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    int cnt_rr [3];
    int cnt_fp [3];
    rst_n = 1'b0;
    m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hwdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    m3_haddr = '0; m3_htrans = '0; m3_hwrite = '0; m3_hsize = '0; m3_hwdata = '0;
    hrdata3 = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_rr[i] = 0;
      cnt_fp[i] = 0;
    end

    // Reset state
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_gnt", gnt, 2'b01);
    chk("rst_mhready", m_hready, 2'b11);
    chk("rst_mhresp", m_hresp, 2'b00);
    chk("rst_hwdata", hwdata, 64'h0);
    chk("rst_htrans", htrans, IDLE);
    chk("rst_gnt3", rr_gnt, 3'b001);
    @(posedge hclk);
    #1 rst_n = 1'b1;

    // Owner M0 read forwarded in the same cycle
    drv(0, NONSEQ, 32'h100, 1'b0);
    @(negedge hclk);
    chk("r19_htrans", htrans, NONSEQ);
    chk("r19_haddr", haddr, 32'h100);
    nxt();
    drv(0, IDLE, 32'h0, 1'b0);
    hrdata = 64'h0123_4567_89AB_CDEF;
    @(negedge hclk);
    chk("r19_mhready", m_hready, 2'b11);
    chk("r19_hrdata", m_hrdata, 64'h0123_4567_89AB_CDEF);
    chk("r19_idle", htrans, IDLE);
    nxt();

    // Simultaneous M0/M1 requests: M1 captured, issued next cycle with new owner
    drv(0, NONSEQ, 32'h100, 1'b0);
    drv(1, NONSEQ, 32'h200, 1'b0);
    @(negedge hclk);
    chk("r20_c_haddr", haddr, 32'h100);
    chk("r20_c_gnt", gnt, 2'b01);
    nxt();
    drv(0, IDLE, 32'h0, 1'b0);
    drv(1, IDLE, 32'h0, 1'b0);
    @(negedge hclk);
    chk("r20_c1_gnt", gnt, 2'b10);
    chk("r20_c1_htrans", htrans, NONSEQ);
    chk("r20_c1_haddr", haddr, 32'h200);
    chk("r20_c1_mhready", m_hready, 2'b01);
    nxt();
    hready = 1'b0;
    @(negedge hclk);
    chk("r20_c2_mhready_lo", m_hready, 2'b01);
    nxt();
    hready = 1'b1;
    @(negedge hclk);
    chk("r20_c3_mhready_hi", m_hready, 2'b11);
    nxt();

    // M0 write with 2 wait states; M1 captured and issued when HREADY rises
    drv(0, NONSEQ, 32'h300, 1'b1);
    @(negedge hclk);
    chk("r21_a_htrans", htrans, IDLE);
    chk("r21_a_mhready", m_hready, 2'b11);
    nxt();
    drv(0, IDLE, 32'h0, 1'b0);
    m_hwdata[63:0] = 64'hDEADBEEF;
    drv(1, NONSEQ, 32'h400, 1'b1);
    @(negedge hclk);
    chk("r21_a1_haddr", haddr, 32'h300);
    chk("r21_a1_hwrite", hwrite, 1'b1);
    chk("r21_a1_gnt", gnt, 2'b01);
    chk("r21_a1_mhready", m_hready, 2'b10);
    nxt();
    drv(1, IDLE, 32'h0, 1'b0);
    m_hwdata[127:64] = 64'hCAFEF00D;
    hready = 1'b0;
    @(negedge hclk);
    chk("r21_a2_hwdata", hwdata, 64'hDEADBEEF);
    chk("r21_a2_haddr", haddr, 32'h400);
    chk("r21_a2_gnt", gnt, 2'b10);
    chk("r21_a2_mhready", m_hready, 2'b00);
    nxt();
    @(negedge hclk);
    chk("r21_a3_hwdata", hwdata, 64'hDEADBEEF);
    nxt();
    hready = 1'b1;
    @(negedge hclk);
    chk("r21_a4_hwdata", hwdata, 64'hDEADBEEF);
    chk("r21_a4_htrans", htrans, NONSEQ);
    chk("r21_a4_haddr", haddr, 32'h400);
    chk("r21_a4_mhready", m_hready, 2'b01);
    nxt();
    m_hwdata[63:0] = 64'h0;
    @(negedge hclk);
    chk("r21_a5_hwdata", hwdata, 64'hCAFEF00D);
    chk("r21_a5_mhready", m_hready, 2'b11);
    nxt();
    m_hwdata = '0;

    // Two-cycle error response on an M1 transfer
    hresp = 1'b1;
    drv(1, NONSEQ, 32'h500, 1'b0);
    @(negedge hclk);
    chk("r23_e_mhresp_nodv", m_hresp, 2'b00);
    chk("r23_e_haddr", haddr, 32'h500);
    nxt();
    drv(1, IDLE, 32'h0, 1'b0);
    hready = 1'b0;
    @(negedge hclk);
    chk("r23_e1_mhresp", m_hresp, 2'b10);
    chk("r23_e1_mhready", m_hready, 2'b01);
    nxt();
    hready = 1'b1;
    @(negedge hclk);
    chk("r23_e2_mhresp", m_hresp, 2'b10);
    nxt();
    @(negedge hclk);
    chk("r23_e3_mhresp_done", m_hresp, 2'b00);
    nxt();
    hresp = 1'b0;

    // Reset while M1 holds a captured transfer
    hready = 1'b0;
    drv(1, NONSEQ, 32'h200, 1'b0);
    @(negedge hclk);
    chk("r24_f_mhready", m_hready, 2'b11);
    nxt();
    drv(1, IDLE, 32'h0, 1'b0);
    @(negedge hclk);
    chk("r24_f1_mhready", m_hready, 2'b01);
    chk("r24_f1_haddr", haddr, 32'h200);
    rst_n = 1'b0;
    #1;
    chk("r24_rst_gnt", gnt, 2'b01);
    chk("r24_rst_mhready", m_hready, 2'b11);
    chk("r24_rst_htrans", htrans, IDLE);
    nxt();
    rst_n = 1'b1;
    hready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge hclk);
      chk("r24_post_htrans", htrans, IDLE);
      chk("r24_post_haddr", haddr, 32'h0);
      chk("r24_post_mhready", m_hready, 2'b11);
      nxt();
    end

    // SEQ beat keeps ownership while another master waits
    drv(0, NONSEQ, 32'h600, 1'b0);
    @(negedge hclk);
    chk("seq_g_haddr", haddr, 32'h600);
    nxt();
    drv(0, SEQ, 32'h604, 1'b0);
    drv(1, NONSEQ, 32'h700, 1'b0);
    @(negedge hclk);
    chk("seq_g1_htrans", htrans, SEQ);
    chk("seq_g1_haddr", haddr, 32'h604);
    nxt();
    drv(0, IDLE, 32'h0, 1'b0);
    drv(1, IDLE, 32'h0, 1'b0);
    @(negedge hclk);
    chk("seq_g2_gnt_lock", gnt, 2'b01);
    chk("seq_g2_htrans", htrans, IDLE);
    nxt();
    @(negedge hclk);
    chk("seq_g3_gnt", gnt, 2'b10);
    chk("seq_g3_haddr", haddr, 32'h700);
    nxt();

    // Fairness with three masters continuously requesting
    m3_haddr  = {32'h3000, 32'h2000, 32'h1000};
    m3_htrans = {NONSEQ, NONSEQ, NONSEQ};
    m3_hsize  = {3'b010, 3'b010, 3'b010};
    for (int c = 0; c < 12; c++) begin
      @(negedge hclk);
      for (int j = 0; j < 3; j++) begin
        if (rr_htrans != IDLE && rr_gnt[j]) cnt_rr[j]++;
        if (fp_htrans != IDLE && fp_gnt[j]) cnt_fp[j]++;
      end
      nxt();
    end
    m3_htrans = '0;
    chk("r22_rr_m0", 64'(cnt_rr[0]), 64'd4);
    chk("r22_rr_m1", 64'(cnt_rr[1]), 64'd4);
    chk("r22_rr_m2", 64'(cnt_rr[2]), 64'd4);
    chk("r22_fp_m2", 64'(cnt_fp[2]), 64'd0);
    chk("r22_fp_total", 64'(cnt_fp[0] + cnt_fp[1] + cnt_fp[2]), 64'd12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
